imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for instruction memory: drives the write port (we/waddr/wdata) of the imem instance, which the core only ever reads.
- Accepts a little-endian byte stream over a valid/ready handshake from a host link.
- Assembles 32-bit words and writes them to consecutive word addresses.
- Holds the core in reset until the image is loaded and its checksum verifies.

Parameters:
- DATAWIDTH, 32, data word width; only 32 supported (4 bytes per word).
- NUMWORDS, 4096, imem depth in words; upper bound for the image word count.
- BASE_ADDR, 0, byte address of the first written word; 32 bits, word aligned.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse; restarts loading from S_DONE or S_ERR; ignored in other states.
- in_valid_i  input  1  byte on in_data_i is valid.
- in_data_i  input  8  stream byte.
- in_ready_o  output  1  loader accepts a byte this cycle.
- we_o  output  1  imem write enable, one-cycle pulse per word.
- waddr_o  output  32  imem byte write address.
- wdata_o  output  DATAWIDTH  imem write data.
- cpu_hold_o  output  1  holds the core in reset while 1.
- done_o  output  1  image loaded and checksum OK.
- err_o  output  1  load failed (oversize or bad checksum).

Behaviour:
- A byte is accepted on a rising edge where in_valid_i && in_ready_o. No other edge changes stream state.
- Stream format: count low byte, count high byte (N, 16-bit word count), then 4*N data bytes (each word LSB first), then one checksum byte.
- Checksum byte must equal the XOR of every preceding byte, header included.
- States: S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM, S_DONE, S_ERR.
- in_ready_o = 1 in S_HDR_LO, S_HDR_HI, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. No backpressure while loading.
- Transitions:
  - S_HDR_LO: accept -> S_HDR_HI.
  - S_HDR_HI: accept -> S_ERR if N > NUMWORDS; else -> S_CSUM if N == 0; else -> S_DATA.
  - S_DATA: on acceptance of the 4th byte of word N-1 -> S_CSUM.
  - S_CSUM: accept -> S_DONE on match, S_ERR on mismatch.
  - S_DONE / S_ERR: start_i -> S_HDR_LO. Word index, byte index and running XOR all clear; the address pointer returns to BASE_ADDR.
- Byte assembly: byte k of a word (k = 0..3) lands in bits [8k+7:8k].
- Write timing:
  - The edge accepting byte 3 registers we_o=1, wdata_o = assembled word, waddr_o = BASE_ADDR + 4*i, where i is the word index from 0.
  - we_o is high for exactly one cycle, the cycle after that acceptance.
  - Latency from last byte to write: 1 cycle.
  - waddr_o/wdata_o hold their last values when we_o=0.
- Byte accepted in the same cycle as a we_o pulse: allowed, no stall; the next word assembles normally.
- waddr arithmetic is 32-bit, no wrap. N <= NUMWORDS keeps addresses in range.
- Outputs by state:
  - cpu_hold_o = 1 in every state except S_DONE.
  - done_o = 1 only in S_DONE.
  - err_o = 1 only in S_ERR.
  - All three are registered.
- Reset (rst_i low, asynchronous, mid-operation included):
  - state S_HDR_LO, we_o 0, waddr_o BASE_ADDR, wdata_o 0.
  - cpu_hold_o 1, done_o 0, err_o 0.
  - Byte/word counters and XOR cleared.
  - Partially written imem contents are not cleaned up; a fresh full load overwrites them.
- start_i with in_valid_i in the same cycle from S_DONE: the byte is not accepted (ready is 0 that cycle).

Test Plan:
- Stream 02 00 44 33 22 11 DD CC BB AA 46 -> two we_o pulses: (0x0, 0x11223344), then (0x4, 0xAABBCCDD). done_o=1, cpu_hold_o=0, err_o=0.
- Stream 00 00 00 -> no we_o pulses; done_o=1 after the checksum byte.
- Same as the first case but checksum 47 -> both writes occur, err_o=1, cpu_hold_o stays 1, done_o=0.
- Header 01 10 (N=4097) -> S_ERR right after the second byte, no writes, in_ready_o=0.
- First stream with in_valid_i toggling randomly (gaps of 0-5 cycles) -> identical writes and done. Each we_o occurs exactly 1 cycle after the 4th byte of its word is accepted.
- rst_i low after 6 bytes of the first stream, then the full first stream -> outputs at reset values during reset, then a correct load with done_o=1. Follow with start_i and a BASE_ADDR=0x100 build -> writes at 0x100/0x104.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Takes a little-endian byte stream (16-bit word count, 4*N data bytes,
// XOR checksum byte), writes 32-bit words to consecutive imem addresses and
// keeps the core held in reset until the whole image has loaded and verified.
//
// Handshake: a byte transfers on a rising clk_i edge where in_valid_i and
// in_ready_o are both 1; in_ready_o depends only on the current state, so it
// never depends on in_valid_i, and no other edge changes stream state.
module imem_loader #(
  parameter int          DATAWIDTH = 32,
  parameter int          NUMWORDS  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  input  logic [7:0]           in_data_i,
  output logic                 in_ready_o,
  output logic                 we_o,
  output logic [31:0]          waddr_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  output logic                 cpu_hold_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [31:0] NUM_WORDS_W = NUMWORDS;

  // State and datapath registers; state_q is the observable FSM state.
  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           buf_q, buf_d;
  logic                  we_q, we_d;
  logic [31:0]           waddr_q, waddr_d;
  logic [DATAWIDTH-1:0]  wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [15:0]           hdr_count;
  logic [31:0]           hdr_count_ext;

  assign in_ready_o    = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                         (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept        = in_valid_i && in_ready_o;
  assign hdr_count     = {in_data_i, cnt_q[7:0]};
  assign hdr_count_ext = {16'h0000, hdr_count};

  // Next-state, byte assembly, write generation and status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_HDR_LO: begin
        if (accept) begin
          cnt_d[7:0] = in_data_i;
          xor_d      = xor_q ^ in_data_i;
          state_d    = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          cnt_d = hdr_count;
          xor_d = xor_q ^ in_data_i;
          if (hdr_count_ext > NUM_WORDS_W) begin
            state_d = S_ERR;
          end else if (hdr_count == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: buf_d[7:0]   = in_data_i;
            2'd1: buf_d[15:8]  = in_data_i;
            2'd2: buf_d[23:16] = in_data_i;
            default: begin
              // Fourth byte completes the word: write it out next cycle.
              we_d       = 1'b1;
              wdata_d    = {in_data_i, buf_q};
              waddr_d    = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              word_idx_d = word_idx_q + 16'd1;
              if ((word_idx_q + 16'd1) == cnt_q) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        // Restart: all stream bookkeeping clears; word index 0 maps back
        // to BASE_ADDR. waddr_o/wdata_o keep their last written values.
        if (start_i) begin
          state_d    = S_HDR_LO;
          cnt_d      = 16'd0;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
          xor_d      = 8'd0;
          buf_d      = 24'd0;
        end
      end
      default: begin
        state_d = S_HDR_LO;
      end
    endcase

    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // Single register bank for the FSM, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_HDR_LO;
      cnt_q      <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      xor_q      <= 8'd0;
      buf_q      <= 24'd0;
      we_q       <= 1'b0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      xor_q      <= xor_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
